// File: rtl/mips_decode_issue.sv
// Decode/issue stage for a small MIPS-like pipeline: register file with write bypass,
// opcode decode, two-entry scoreboard interlock, ID/EX register, flush and sticky halt.
module mips_decode_issue #(
    parameter int DATA = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_valid,
    input  logic [31:0]     if_instr,
    output logic            if_ready,
    input  logic            flush,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [DATA-1:0] wb_data,
    output logic            ex_valid,
    output logic [DATA-1:0] ex_a,
    output logic [DATA-1:0] ex_b,
    output logic [2:0]      ex_aluop,
    output logic            ex_jump,
    output logic [4:0]      ex_dest,
    output logic            ex_wen,
    output logic            ex_mem_rd,
    output logic            ex_mem_wr,
    output logic [DATA-1:0] ex_store_data,
    output logic            halted
);
    localparam logic [5:0] OP_XORI = 6'h0B;
    localparam logic [5:0] OP_LDW  = 6'h0C;
    localparam logic [5:0] OP_STW  = 6'h0D;
    localparam logic [5:0] OP_BZ   = 6'h0E;
    localparam logic [5:0] OP_BEQ  = 6'h0F;
    localparam logic [5:0] OP_JR   = 6'h10;
    localparam logic [5:0] OP_HALT = 6'h11;

    logic [5:0]      opcode;
    logic [4:0]      rs, rt, rd;
    logic [DATA-1:0] imm_ext;
    logic [DATA-1:0] rs_val, rt_val;
    logic [DATA-1:0] rf_q [NREG];
    logic [DATA-1:0] rf_d [NREG];

    logic [DATA-1:0] dec_b, dec_store;
    logic [2:0]      dec_aluop;
    logic [4:0]      dec_dest;
    logic            dec_jump, dec_wen, dec_mem_rd, dec_mem_wr, dec_halt;
    logic            rs_src, rt_src;

    logic            s0_valid, rs_hit, rt_hit, stall, issue;
    logic            s1_valid_q, s1_valid_d;
    logic [4:0]      s1_dest_q, s1_dest_d;
    logic            halted_q, halted_d;
    logic            ex_valid_q, ex_valid_d, ex_jump_q, ex_jump_d, ex_wen_q, ex_wen_d;
    logic            ex_mem_rd_q, ex_mem_rd_d, ex_mem_wr_q, ex_mem_wr_d;
    logic [DATA-1:0] ex_a_q, ex_a_d, ex_b_q, ex_b_d, ex_store_q, ex_store_d;
    logic [2:0]      ex_aluop_q, ex_aluop_d;
    logic [4:0]      ex_dest_q, ex_dest_d;

    assign opcode  = if_instr[31:26];
    assign rs      = if_instr[25:21];
    assign rt      = if_instr[20:16];
    assign rd      = if_instr[15:11];
    assign imm_ext = {{(DATA-16){if_instr[15]}}, if_instr[15:0]};

    // R0 is hardwired to zero; a same-cycle writeback is visible to the read ports.
    always_comb begin
        rs_val = rf_q[rs];
        rt_val = rf_q[rt];
        if (rs == 5'd0)
            rs_val = '0;
        else if (wb_en && wb_addr == rs)
            rs_val = wb_data;
        if (rt == 5'd0)
            rt_val = '0;
        else if (wb_en && wb_addr == rt)
            rt_val = wb_data;
    end

    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_addr != 5'd0)
            rf_d[wb_addr] = wb_data;
    end

    // Opcodes 0x00-0x0B pair up as R-type (even) / I-type (odd) sharing one ALU op.
    always_comb begin
        dec_b      = '0;
        dec_store  = '0;
        dec_aluop  = 3'b000;
        dec_dest   = 5'd0;
        dec_jump   = 1'b0;
        dec_wen    = 1'b0;
        dec_mem_rd = 1'b0;
        dec_mem_wr = 1'b0;
        dec_halt   = 1'b0;
        rs_src     = 1'b1;
        rt_src     = 1'b0;
        if (opcode <= OP_XORI) begin
            dec_aluop = opcode[3:1];
            dec_wen   = 1'b1;
            if (!opcode[0]) begin
                dec_b    = rt_val;
                dec_dest = rd;
                rt_src   = 1'b1;
            end else begin
                dec_b    = imm_ext;
                dec_dest = rt;
            end
        end else begin
            case (opcode)
                OP_LDW: begin
                    dec_b      = imm_ext;
                    dec_dest   = rt;
                    dec_wen    = 1'b1;
                    dec_mem_rd = 1'b1;
                end
                OP_STW: begin
                    dec_b      = imm_ext;
                    dec_store  = rt_val;
                    dec_mem_wr = 1'b1;
                    rt_src     = 1'b1;
                end
                OP_BZ:   dec_aluop = 3'b110;
                OP_BEQ: begin
                    dec_aluop = 3'b111;
                    dec_b     = rt_val;
                    rt_src    = 1'b1;
                end
                OP_JR:   dec_jump = 1'b1;
                OP_HALT: begin
                    dec_halt = 1'b1;
                    rs_src   = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // No forwarding: any source still pending in EX or MEM holds the instruction back.
    always_comb begin
        s0_valid = ex_valid_q & ex_wen_q;
        rs_hit   = rs_src && rs != 5'd0 &&
                   ((s0_valid && ex_dest_q == rs) || (s1_valid_q && s1_dest_q == rs));
        rt_hit   = rt_src && rt != 5'd0 &&
                   ((s0_valid && ex_dest_q == rt) || (s1_valid_q && s1_dest_q == rt));
        stall    = if_valid & (rs_hit | rt_hit);
        if_ready = !halted_q && (flush || !stall);
        issue    = if_valid && if_ready && !flush;
    end

    always_comb begin
        ex_valid_d  = 1'b0;
        ex_a_d      = '0;
        ex_b_d      = '0;
        ex_aluop_d  = 3'b000;
        ex_jump_d   = 1'b0;
        ex_dest_d   = 5'd0;
        ex_wen_d    = 1'b0;
        ex_mem_rd_d = 1'b0;
        ex_mem_wr_d = 1'b0;
        ex_store_d  = '0;
        halted_d    = halted_q;
        s1_valid_d  = s0_valid;
        s1_dest_d   = ex_dest_q;
        if (issue) begin
            ex_valid_d  = 1'b1;
            ex_a_d      = rs_val;
            ex_b_d      = dec_b;
            ex_aluop_d  = dec_aluop;
            ex_jump_d   = dec_jump;
            ex_dest_d   = dec_dest;
            ex_wen_d    = dec_wen;
            ex_mem_rd_d = dec_mem_rd;
            ex_mem_wr_d = dec_mem_wr;
            ex_store_d  = dec_store;
            halted_d    = halted_q | dec_halt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++)
                rf_q[i] <= '0;
            ex_valid_q  <= 1'b0;
            ex_a_q      <= '0;
            ex_b_q      <= '0;
            ex_aluop_q  <= 3'b000;
            ex_jump_q   <= 1'b0;
            ex_dest_q   <= 5'd0;
            ex_wen_q    <= 1'b0;
            ex_mem_rd_q <= 1'b0;
            ex_mem_wr_q <= 1'b0;
            ex_store_q  <= '0;
            halted_q    <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_dest_q   <= 5'd0;
        end else begin
            rf_q        <= rf_d;
            ex_valid_q  <= ex_valid_d;
            ex_a_q      <= ex_a_d;
            ex_b_q      <= ex_b_d;
            ex_aluop_q  <= ex_aluop_d;
            ex_jump_q   <= ex_jump_d;
            ex_dest_q   <= ex_dest_d;
            ex_wen_q    <= ex_wen_d;
            ex_mem_rd_q <= ex_mem_rd_d;
            ex_mem_wr_q <= ex_mem_wr_d;
            ex_store_q  <= ex_store_d;
            halted_q    <= halted_d;
            s1_valid_q  <= s1_valid_d;
            s1_dest_q   <= s1_dest_d;
        end
    end

    assign ex_valid      = ex_valid_q;
    assign ex_a          = ex_a_q;
    assign ex_b          = ex_b_q;
    assign ex_aluop      = ex_aluop_q;
    assign ex_jump       = ex_jump_q;
    assign ex_dest       = ex_dest_q;
    assign ex_wen        = ex_wen_q;
    assign ex_mem_rd     = ex_mem_rd_q;
    assign ex_mem_wr     = ex_mem_wr_q;
    assign ex_store_data = ex_store_q;
    assign halted        = halted_q;

endmodule
